// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch execute sequencer.
// The funct3 decode stays with the external comparator, so this package
// carries no funct3 constants of its own.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESOLVE,
    REDIRECT
  } branch_ctrl_state_t;

  // B-type immediate: 13 bits including the implicit zero LSB, still unsigned-extended.
  function automatic logic [12:0] b_imm(input logic [31:0] instr);
    return {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch target: pc + sign-extended B-immediate, wrapping mod 2^XLEN.
// Ports:
//   pc_i          branch PC
//   instr_i       raw branch instruction (only immediate fields are used)
//   target_o      computed target
//   misaligned_o  target not 4-byte aligned
module branch_target_calc
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] target_o,
  output logic            misaligned_o
);

  logic [12:0]     imm;
  logic [XLEN-1:0] imm_sext;
  logic            unused_instr_bits;

  assign imm               = b_imm(instr_i);
  assign imm_sext          = {{(XLEN-13){imm[12]}}, imm};
  assign target_o          = pc_i + imm_sext;
  assign misaligned_o      = |target_o[1:0];
  assign unused_instr_bits = ^{instr_i[24:12], instr_i[6:0]};

endmodule

// File: rtl/branch_ctrl.sv
// Execute-stage sequencer around an external registered branch comparator.
// Accepts one branch op, drives the comparator, waits for its registered
// result and either redirects fetch (with a one-cycle flush), flags a
// misaligned taken target, or retires silently.
// Ports:
//   req_*        issue handshake and operands
//   cmp_*        operands to / result from the external comparator
//   redirect_*   redirect handshake to fetch
//   flush        one-cycle pulse when a redirect is raised
//   misalign_err one-cycle pulse on a taken, misaligned target
//   busy         controller not idle
// Optional feature macro BRANCH_CTRL_STATS_EN adds stat_clr, stat_taken,
// stat_not_taken (saturating outcome counters).
//
// state    | meaning
// IDLE     | ready for a new op, cmp_* hold last operands
// ISSUE    | operands stable, comparator samples at the end of this cycle
// RESOLVE  | comparator result valid, decide outcome
// REDIRECT | redirect held until fetch accepts it
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_pc,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [31:0]     req_instr,
  output logic [XLEN-1:0] cmp_rs1,
  output logic [XLEN-1:0] cmp_rs2,
  output logic [31:0]     cmp_instr,
  input  logic            cmp_taken,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misalign_err,
  output logic            busy
`ifdef BRANCH_CTRL_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_taken,
  output logic [31:0]     stat_not_taken
`endif
);

  branch_ctrl_state_t state_q, state_d;
  logic [XLEN-1:0]    cmp_rs1_q, cmp_rs2_q, redirect_pc_q;
  logic [31:0]        cmp_instr_q;
  logic               misaligned_q;
  logic [XLEN-1:0]    target;
  logic               target_misaligned;
  logic               accept;

  branch_target_calc #(.XLEN(XLEN)) u_target (
    .pc_i         (req_pc),
    .instr_i      (req_instr),
    .target_o     (target),
    .misaligned_o (target_misaligned)
  );

  assign accept = req_valid && (state_q == IDLE);

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    redirect_valid = 1'b0;
    flush          = 1'b0;
    misalign_err   = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ISSUE;
      end
      ISSUE: state_d = RESOLVE;
      RESOLVE: begin
        if (!cmp_taken) begin
          state_d = IDLE;
        end else if (misaligned_q) begin
          misalign_err = 1'b1;
          state_d      = IDLE;
        end else begin
          // A ready fetch in the first redirect cycle completes the handshake here.
          redirect_valid = 1'b1;
          flush          = 1'b1;
          state_d        = redirect_ready ? IDLE : REDIRECT;
        end
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmp_rs1_q     <= '0;
      cmp_rs2_q     <= '0;
      cmp_instr_q   <= '0;
      redirect_pc_q <= RESET_PC;
      misaligned_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cmp_rs1_q     <= req_rs1;
        cmp_rs2_q     <= req_rs2;
        cmp_instr_q   <= req_instr;
        redirect_pc_q <= target;
        misaligned_q  <= target_misaligned;
      end
    end
  end

  assign cmp_rs1     = cmp_rs1_q;
  assign cmp_rs2     = cmp_rs2_q;
  assign cmp_instr   = cmp_instr_q;
  assign redirect_pc = redirect_pc_q;
  assign busy        = (state_q != IDLE);

`ifdef BRANCH_CTRL_STATS_EN
  logic [31:0] stat_taken_q, stat_not_taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else if (stat_clr) begin
      stat_taken_q     <= '0;
      stat_not_taken_q <= '0;
    end else if (state_q == RESOLVE) begin
      // Misaligned taken ops still count as taken.
      if (cmp_taken) begin
        if (stat_taken_q != 32'hFFFF_FFFF) stat_taken_q <= stat_taken_q + 32'd1;
      end else begin
        if (stat_not_taken_q != 32'hFFFF_FFFF) stat_not_taken_q <= stat_not_taken_q + 32'd1;
      end
    end
  end

  assign stat_taken     = stat_taken_q;
  assign stat_not_taken = stat_not_taken_q;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
module tb_branch_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc, req_rs1, req_rs2, req_instr;
  logic [31:0] cmp_rs1, cmp_rs2, cmp_instr;
  logic        cmp_taken;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush, misalign_err, busy;
`ifdef BRANCH_CTRL_STATS_EN
  logic        stat_clr;
  logic [31:0] stat_taken, stat_not_taken;
`endif

  logic rr_force_en, rr_force_val, rr_rand;
  assign redirect_ready = rr_force_en ? rr_force_val : rr_rand;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  branch_ctrl #(.XLEN(32), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_pc         (req_pc),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_instr      (req_instr),
    .cmp_rs1        (cmp_rs1),
    .cmp_rs2        (cmp_rs2),
    .cmp_instr      (cmp_instr),
    .cmp_taken      (cmp_taken),
    .redirect_valid (redirect_valid),
    .redirect_ready (redirect_ready),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .misalign_err   (misalign_err),
    .busy           (busy)
`ifdef BRANCH_CTRL_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_taken     (stat_taken),
    .stat_not_taken (stat_not_taken)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1 rr_rand = ($urandom_range(0, 2) == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // RISC-V branch rule by funct3; reserved encodings never take.
  function automatic logic br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // Target by weighting the scattered immediate bits arithmetically.
  function automatic logic [31:0] b_target(input logic [31:0] pc, input logic [31:0] ins);
    int off;
    off = 0;
    if (ins[31]) off -= 4096;
    if (ins[7]) off += 2048;
    off += int'(ins[30:25]) * 32;
    off += int'(ins[11:8]) * 2;
    return pc + 32'(off);
  endfunction

  function automatic logic [31:0] mk_b(input int imm, input logic [2:0] f3);
    logic [12:0] i;
    i = 13'(imm);
    return {i[12], i[10:5], 5'd2, 5'd1, f3, i[4:1], i[11], 7'b1100011};
  endfunction

  // External registered comparator.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cmp_taken <= 1'b0;
    else        cmp_taken <= br_taken(cmp_instr[14:12], cmp_rs1, cmp_rs2);
  end

  // Reference model: op in flight, cycle of acceptance, and its outcome.
  int unsigned cyc, acc;
  logic        inflight, m_taken;
  logic [31:0] m_target, m_rs1, m_rs2, m_instr;
  logic [31:0] age;
  logic        m_al, m_redir;
  assign age     = cyc - acc;
  assign m_al    = (m_target[1:0] == 2'b00);
  assign m_redir = inflight && m_taken && m_al;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      cyc      <= 0;
      acc      <= 0;
      m_taken  <= 1'b0;
      m_target <= RPC;
      m_rs1    <= '0;
      m_rs2    <= '0;
      m_instr  <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!inflight) begin
        if (req_valid) begin
          inflight <= 1'b1;
          acc      <= cyc + 1;
          m_rs1    <= req_rs1;
          m_rs2    <= req_rs2;
          m_instr  <= req_instr;
          m_target <= b_target(req_pc, req_instr);
          m_taken  <= br_taken(req_instr[14:12], req_rs1, req_rs2);
        end
      end else if (age >= 1) begin
        if (!m_redir || redirect_ready) inflight <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("req_ready", req_ready, !inflight);
      chk("busy", busy, inflight);
      chk("redirect_valid", redirect_valid, m_redir && age >= 1);
      chk("flush", flush, m_redir && age == 1);
      chk("misalign_err", misalign_err, inflight && m_taken && !m_al && age == 1);
      chk("redirect_pc", redirect_pc, m_target);
      chk("cmp_rs1", cmp_rs1, m_rs1);
      chk("cmp_rs2", cmp_rs2, m_rs2);
      chk("cmp_instr", cmp_instr, m_instr);
    end
  end

  task automatic send(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] ins);
    int n;
    req_valid = 1'b1;
    req_pc    = pc;
    req_rs1   = a;
    req_rs2   = b;
    req_instr = ins;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 100);
    if (!req_ready) chk("accept_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          g, imm;
    logic [2:0]  f3;
    logic [31:0] a, b, pc;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_pc       = '0;
    req_rs1      = '0;
    req_rs2      = '0;
    req_instr    = '0;
    rr_force_en  = 1'b1;
    rr_force_val = 1'b0;
    rr_rand      = 1'b0;
`ifdef BRANCH_CTRL_STATS_EN
    stat_clr     = 1'b0;
`endif
    #12;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, RPC);
    chk("rst_cmp_rs1", cmp_rs1, 0);
    chk("rst_flush", flush, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // BEQ taken, fetch ready immediately.
    rr_force_val = 1'b1;
    send(32'h100, 5, 5, mk_b(16, 3'd0));
    @(negedge clk);
    chk("beq_issue_ready", req_ready, 0);
    @(negedge clk);
    chk("beq_rv", redirect_valid, 1);
    chk("beq_pc", redirect_pc, 32'h110);
    chk("beq_flush", flush, 1);
    @(negedge clk);
    chk("beq_flush_end", flush, 0);
    chk("beq_idle", req_ready, 1);
    @(posedge clk); #1;

    // BNE not taken: ready again three cycles after accept.
    send(32'h180, 7, 7, mk_b(-32, 3'd1));
    @(negedge clk);
    chk("bne_c1_ready", req_ready, 0);
    @(negedge clk);
    chk("bne_c2_ready", req_ready, 0);
    chk("bne_rv", redirect_valid, 0);
    chk("bne_flush", flush, 0);
    @(negedge clk);
    chk("bne_c3_ready", req_ready, 1);
    @(posedge clk); #1;

    // Backward wrap.
    send(32'h4, 9, 9, mk_b(-8, 3'd0));
    repeat (2) @(negedge clk);
    chk("wrap_pc", redirect_pc, 32'hFFFF_FFFC);
    chk("wrap_err", misalign_err, 0);
    chk("wrap_rv", redirect_valid, 1);
    @(posedge clk); #1;

    // Misaligned taken target.
    send(32'h200, 3, 3, mk_b(2, 3'd0));
    repeat (2) @(negedge clk);
    chk("mis_err", misalign_err, 1);
    chk("mis_rv", redirect_valid, 0);
    chk("mis_flush", flush, 0);
    chk("mis_pc", redirect_pc, 32'h202);
    @(negedge clk);
    chk("mis_err_end", misalign_err, 0);
    @(posedge clk); #1;

    // Backpressure on redirect.
    rr_force_val = 1'b0;
    send(32'h300, 1, 2, mk_b(8, 3'd4));
    repeat (2) @(negedge clk);
    chk("bp_rv0", redirect_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rv", redirect_valid, 1);
      chk("bp_pc", redirect_pc, 32'h308);
      chk("bp_busy", busy, 1);
      chk("bp_ready", req_ready, 0);
      chk("bp_flush", flush, 0);
    end
    rr_force_val = 1'b1;
    @(negedge clk);
    chk("bp_exit_rv", redirect_valid, 0);
    chk("bp_exit_ready", req_ready, 1);
    @(posedge clk); #1;

    // Reset while a redirect is pending.
    rr_force_val = 1'b0;
    send(32'h400, 4, 4, mk_b(64, 3'd5));
    repeat (3) @(negedge clk);
    chk("rstmid_rv_before", redirect_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_rv", redirect_valid, 0);
    chk("rstmid_pc", redirect_pc, RPC);
    chk("rstmid_flush", flush, 0);
    chk("rstmid_busy", busy, 0);
`ifdef BRANCH_CTRL_STATS_EN
    chk("rstmid_stat_t", stat_taken, 0);
    chk("rstmid_stat_nt", stat_not_taken, 0);
`endif
    @(negedge clk);
    #2 rst_n = 1'b1;
    rr_force_val = 1'b1;
    @(posedge clk); #1;
    send(32'h500, 6, 6, mk_b(12, 3'd0));
    repeat (2) @(negedge clk);
    chk("post_rst_pc", redirect_pc, 32'h50C);
    chk("post_rst_rv", redirect_valid, 1);
    @(posedge clk); #1;

    // Randomized ops with random fetch backpressure.
    rr_force_en = 1'b0;
    for (int k = 0; k < 300; k++) begin
      g = $urandom_range(0, 2);
      repeat (g) begin
        @(posedge clk); #1;
      end
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
      imm = 2 * int'($urandom_range(0, 4095)) - 4096;
      pc  = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      send(pc, a, b, mk_b(imm, f3));
    end

    rr_force_en  = 1'b1;
    rr_force_val = 1'b1;
    repeat (6) @(negedge clk);
    chk("drain_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Execute-stage sequencer for the registered branch comparator.
- Accepts one conditional-branch op at a time from issue over a valid/ready handshake.
- Drives the comparator operands, waits for its one-cycle registered result, and computes the B-type target.
- Issues a redirect plus a one-cycle flush to fetch, or retires the branch silently when not taken.

Parameters:
- XLEN, 32, operand/PC width.
- RESET_PC, 32'h0000_0000, value held on redirect_pc out of reset.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  branch op offered by issue.
- req_ready  out  1  controller can accept op.
- req_pc  in  XLEN  PC of branch.
- req_rs1  in  XLEN  rs1 operand value.
- req_rs2  in  XLEN  rs2 operand value.
- req_instr  in  32  raw branch instruction.
- cmp_rs1  out  XLEN  operand to comparator.
- cmp_rs2  out  XLEN  operand to comparator.
- cmp_instr  out  32  instruction to comparator (funct3 source).
- cmp_taken  in  1  comparator result, valid one cycle after operands are driven.
- redirect_valid  out  1  redirect request to fetch.
- redirect_ready  in  1  fetch accepts redirect.
- redirect_pc  out  XLEN  branch target.
- flush  out  1  one-cycle pulse, kill younger instructions.
- misalign_err  out  1  one-cycle pulse, taken target not 4-byte aligned.
- busy  out  1  state != IDLE.

Behaviour:
- Reset values (async, rst_n low):
  - state = IDLE; req_ready = 1.
  - cmp_* = 0; redirect_valid = 0; redirect_pc = RESET_PC.
  - flush = 0; misalign_err = 0; busy = 0.
- States: IDLE, ISSUE, RESOLVE, REDIRECT.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch pc, rs1, rs2 and instr into cmp_* registers, then go to ISSUE.
  - Compute target = pc + sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}), mod 2^XLEN (wrap, no overflow flag), and latch it into redirect_pc.
- ISSUE:
  - cmp_* are stable for this cycle, which is the comparator's sampling edge.
  - Go to RESOLVE. req_ready = 0.
- RESOLVE:
  - Sample cmp_taken.
  - Not taken: back to IDLE, no outputs asserted.
  - Taken and redirect_pc[1:0] != 0: pulse misalign_err, no redirect, no flush, back to IDLE.
  - Taken and aligned: assert redirect_valid, pulse flush (this cycle only), go to REDIRECT.
- REDIRECT:
  - Hold redirect_valid and redirect_pc stable until redirect_ready.
  - On redirect_ready, deassert redirect_valid next cycle and return to IDLE.
  - redirect_ready sampled in the same cycle redirect_valid first rises completes the handshake that cycle.
- Latency: accept to resolve = 2 cycles. Back-to-back not-taken ops have a throughput of 1 per 3 cycles. req_ready deasserts the cycle after accept.
- cmp_* hold their last value in IDLE (no toggle, power).
- funct3 010/011 (reserved): comparator returns 0, so the op is treated as not taken. No error raised.
- rst_n asserted mid-operation (any state): immediate return to IDLE. Any pending redirect is dropped; flush is not generated.
- req_valid during a non-IDLE state is ignored; the issuer must hold it (standard valid/ready).

Optional Feature:
- Macro: BRANCH_CTRL_STATS_EN.
- When defined, adds outputs stat_taken and stat_not_taken (32 bits each) and input stat_clr.
  - Counters increment in RESOLVE on outcome; a misaligned-taken op counts as taken.
  - Counters saturate at 32'hFFFF_FFFF.
  - stat_clr zeroes both, and takes priority over increment.
  - Counters reset to 0 on rst_n.
- When undefined, the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package branch_pkg:
  - state enum branch_ctrl_state_t {IDLE, ISSUE, RESOLVE, REDIRECT}.
  - B-immediate extraction function.
  - Funct3 constants (reuse the existing riscv defines, no redefinition).
- One sub-module: branch_target_calc, combinational pc + B-imm with alignment flag output.
- The comparator is instantiated outside this block, not inside.

Test Plan:
- BEQ taken: pc=0x100, rs1=rs2=5, imm=+16 -> redirect_valid in RESOLVE cycle, redirect_pc=0x110, flush pulse of exactly 1 cycle, redirect_ready=1 -> IDLE next cycle.
- BNE not taken: rs1=rs2=7 -> no redirect/flush, req_ready high again 3 cycles after accept.
- Backward wrap: pc=0x0000_0004, imm=-8, taken -> redirect_pc=0xFFFF_FFFC, no error.
- Misaligned: pc=0x200, imm=+2 (instr[8]=1), taken -> misalign_err pulse, redirect_valid stays 0, flush stays 0.
- Backpressure: taken, redirect_ready held 0 for 5 cycles -> redirect_valid/redirect_pc stable, busy=1, req_ready=0. Then ready=1 -> exit after one cycle.
- Reset mid-REDIRECT: assert rst_n low while redirect_valid=1 -> redirect_valid=0 and redirect_pc=RESET_PC asynchronously. After release, next branch resolves normally; with BRANCH_CTRL_STATS_EN, counters read 0.
